// File: rtl/aes_pkg.sv
// Shared AES byte type and S-box constant tables.
// Pure constants; no logic or latency.
// No handshake; consumed by combinational lookups.
package aes_pkg;

    localparam int MAX_LANES = 16;

    typedef logic [7:0] byte_t;

    localparam byte_t AES_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t AES_INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sbox_lane.sv
// One-byte forward/inverse AES S-box lookup.
// Purely combinational, zero latency.
// No handshake; the enclosing pipeline owns flow control.
module sbox_lane
    import aes_pkg::*;
(
    input  byte_t data,
    input  logic  inv,
    output byte_t result
);

    // Select the table for this beat's direction and look the byte up.
    always_comb begin
        result = inv ? AES_INV_SBOX[data] : AES_SBOX[data];
    end

endmodule

// File: rtl/sub_bytes_pipe.sv
// Parallel AES SubBytes over LANES bytes, forward or inverse per beat.
// Latency STAGES cycles (1 or 2), throughput one beat per clock.
// All stages stall together while out_valid && !out_ready; in_ready follows.
module sub_bytes_pipe
    import aes_pkg::*;
#(
    parameter int LANES  = 16,
    parameter int STAGES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [8*LANES-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_inv,
    output logic [8*LANES-1:0] out_data,
    output logic               busy
);

    // The whole pipe moves as one: it advances whenever the output slot is
    // empty or being drained this cycle.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Operands seen by the lookup, either straight from the input port or
    // from the optional decode-side register.
    logic               lut_valid;
    logic               lut_inv;
    logic [8*LANES-1:0] lut_in;
    logic [8*LANES-1:0] lut_out;
    logic               front_busy;

    generate
        if (STAGES == 2) begin : g_two_stage
            logic               s1_valid;
            logic               s1_inv;
            logic [8*LANES-1:0] s1_data;

            // Front register: captures the raw beat so the table decode gets
            // a full cycle; an empty input cycle becomes a bubble here.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_valid <= 1'b0;
                    s1_inv   <= 1'b0;
                    s1_data  <= '0;
                end else if (advance) begin
                    s1_valid <= in_valid;
                    if (in_valid) begin
                        s1_inv  <= in_inv;
                        s1_data <= in_data;
                    end
                end
            end

            assign lut_valid  = s1_valid;
            assign lut_inv    = s1_inv;
            assign lut_in     = s1_data;
            assign front_busy = s1_valid;
        end else begin : g_one_stage
            assign lut_valid  = in_valid;
            assign lut_inv    = in_inv;
            assign lut_in     = in_data;
            assign front_busy = 1'b0;
        end
    endgenerate

    // Lanes never interact; each byte gets its own lookup.
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            sbox_lane u_sbox_lane (
                .data   (lut_in[8*i +: 8]),
                .inv    (lut_inv),
                .result (lut_out[8*i +: 8])
            );
        end
    endgenerate

    // Output register: data and direction only change when a real beat
    // moves in, so a stalled or idle output keeps its last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_inv   <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            out_valid <= lut_valid;
            if (lut_valid) begin
                out_inv  <= lut_inv;
                out_data <= lut_out;
            end
        end
    end

    assign busy = out_valid || front_busy;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Self-checking bench for sub_bytes_pipe in two configurations.
// A (LANES=4, STAGES=1) and B (LANES=16, STAGES=2) share clock and reset.
// Expected beats come from an independent GF(2^8) S-box model.
module tb_sub_bytes_pipe;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Config A: key-schedule shape
    logic         iv1 = 1'b0, inv1 = 1'b0, or1 = 1'b1;
    logic [31:0]  d1 = '0;
    logic         ir1, ov1, oinv1, busy1;
    logic [31:0]  od1;

    // Config B: full-state shape, two stages
    logic         iv2 = 1'b0, inv2 = 1'b0, or2 = 1'b1;
    logic [127:0] d2 = '0;
    logic         ir2, ov2, oinv2, busy2;
    logic [127:0] od2;

    sub_bytes_pipe #(.LANES(4), .STAGES(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(iv1), .in_ready(ir1), .in_inv(inv1), .in_data(d1),
        .out_valid(ov1), .out_ready(or1), .out_inv(oinv1), .out_data(od1),
        .busy(busy1)
    );

    sub_bytes_pipe #(.LANES(16), .STAGES(2)) dut2 (
        .clk(clk), .reset(reset),
        .in_valid(iv2), .in_ready(ir2), .in_inv(inv2), .in_data(d2),
        .out_valid(ov2), .out_ready(or2), .out_inv(oinv2), .out_data(od2),
        .busy(busy2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   fwd_tab [256];
    logic [7:0]   inv_tab [256];
    logic [32:0]  q1 [$];
    logic [128:0] q2 [$];

    // ---------------- reference model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] a);
        return {a[6:0], a[7]};
    endfunction

    task automatic build_model();
        logic [7:0] b, r, s;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            r = b; s = b;
            for (int k = 0; k < 4; k++) begin
                r = rotl1(r);
                s = s ^ r;
            end
            fwd_tab[x] = s ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
    endtask

    function automatic logic [127:0] sub_model(input logic [127:0] d, input logic inv, input int lanes);
        logic [127:0] r = '0;
        for (int i = 0; i < lanes; i++)
            r[8*i +: 8] = inv ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
        return r;
    endfunction

    // ---------------- scoreboard monitors ----------------
    // Pop before push so a same-cycle input never satisfies its own output.
    always @(negedge clk) begin
        logic [32:0]  got1;
        logic [32:0]  exp1;
        logic [127:0] m;
        if (!reset) begin
            if (ov1 && or1) begin
                n_checks++;
                got1 = {oinv1, od1};
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_a_extra: got beat %h, required no beat", got1);
                end else begin
                    exp1 = q1.pop_front();
                    if (got1 !== exp1) begin
                        n_fail++;
                        $display("FAIL sb_a_beat: got %h, required %h", got1, exp1);
                    end
                end
            end
            if (iv1 && ir1) begin
                m = sub_model({96'b0, d1}, inv1, 4);
                q1.push_back({inv1, m[31:0]});
            end
        end
    end

    always @(negedge clk) begin
        logic [128:0] got2;
        logic [128:0] exp2;
        if (!reset) begin
            if (ov2 && or2) begin
                n_checks++;
                got2 = {oinv2, od2};
                if (q2.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_b_extra: got beat %h, required no beat", got2);
                end else begin
                    exp2 = q2.pop_front();
                    if (got2 !== exp2) begin
                        n_fail++;
                        $display("FAIL sb_b_beat: got %h, required %h", got2, exp2);
                    end
                end
            end
            if (iv2 && ir2) q2.push_back({inv2, sub_model(d2, inv2, 16)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && (q1.size() != 0 || q2.size() != 0); k++) tick();
        repeat (3) tick();
        n_checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending a=%0d b=%0d, required 0 0", q1.size(), q2.size());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2;
        n_checks++;
        if ({ov1, oinv1, od1, busy1} !== 35'b0) begin
            n_fail++;
            $display("FAIL reset_a: got v=%b inv=%b d=%h busy=%b, required all 0", ov1, oinv1, od1, busy1);
        end
        n_checks++;
        if ({ov2, oinv2, od2, busy2} !== 131'b0) begin
            n_fail++;
            $display("FAIL reset_b: got v=%b inv=%b d=%h busy=%b, required all 0", ov2, oinv2, od2, busy2);
        end
        #10 reset = 1'b0;
        tick();
        n_checks++;
        if (ir1 !== 1'b1 || ir2 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b %b, required 1 1", ir1, ir2);
        end
    endtask

    task automatic test_forward_latency();
        or1 = 1'b1;
        iv1 = 1'b1; inv1 = 1'b0; d1 = 32'hFF530100;
        #1;
        n_checks++;
        if (ov1 !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_early: out_valid %b, required 0", ov1);
        end
        tick();
        iv1 = 1'b0;
        n_checks++;
        if (ov1 !== 1'b1 || od1 !== 32'h16ED7C63 || oinv1 !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_known: got v=%b d=%h inv=%b, required 1 16ed7c63 0", ov1, od1, oinv1);
        end
        tick();
        n_checks++;
        if (ov1 !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_single: out_valid %b, required 0", ov1);
        end
    endtask

    task automatic test_inverse_alternate();
        iv1 = 1'b1; inv1 = 1'b1; d1 = 32'h16ED7C63;
        tick();
        n_checks++;
        if (ov1 !== 1'b1 || od1 !== 32'hFF530100 || oinv1 !== 1'b1) begin
            n_fail++;
            $display("FAIL inv_known: got v=%b d=%h inv=%b, required 1 ff530100 1", ov1, od1, oinv1);
        end
        for (int i = 0; i < 8; i++) begin
            inv1 = i[0];
            d1 = $urandom;
            tick();
            n_checks++;
            if (ov1 !== 1'b1 || oinv1 !== i[0]) begin
                n_fail++;
                $display("FAIL alt_beat%0d: got v=%b inv=%b, required 1 %b", i, ov1, oinv1, i[0]);
            end
        end
        iv1 = 1'b0;
        drain();
    endtask

    task automatic test_sweep();
        logic [127:0] d;
        or2 = 1'b1;
        for (int b = 0; b < 32; b++) begin
            for (int i = 0; i < 16; i++) begin
                d[8*i +: 8] = (b < 16) ? 8'((b % 16) * 16 + i) : fwd_tab[(b % 16) * 16 + i];
            end
            iv2 = 1'b1; inv2 = (b >= 16); d2 = d;
            tick();
            if (b == 0) begin
                n_checks++;
                if (ov2 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sweep_lat1: out_valid %b one cycle after accept, required 0", ov2);
                end
            end
            if (b == 1) begin
                n_checks++;
                if (ov2 !== 1'b1 || od2[7:0] !== 8'h63) begin
                    n_fail++;
                    $display("FAIL sweep_lat2: got v=%b lane0=%h, required 1 63", ov2, od2[7:0]);
                end
            end
        end
        iv2 = 1'b0;
        drain();
    endtask

    task automatic test_backpressure();
        logic [127:0] held_d;
        logic         held_inv;
        or2 = 1'b1;
        iv2 = 1'b1; inv2 = 1'b0; d2 = {$urandom, $urandom, $urandom, $urandom};
        tick();
        inv2 = 1'b1; d2 = {$urandom, $urandom, $urandom, $urandom};
        tick();
        or2 = 1'b0;
        inv2 = 1'b0; d2 = {$urandom, $urandom, $urandom, $urandom};
        #1;
        held_d = od2; held_inv = oinv2;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (ir2 !== 1'b0 || ov2 !== 1'b1 || od2 !== held_d || oinv2 !== held_inv) begin
                n_fail++;
                $display("FAIL stall_c%0d: got rdy=%b v=%b inv=%b d=%h, required 0 1 %b %h",
                         c, ir2, ov2, oinv2, od2, held_inv, held_d);
            end
        end
        or2 = 1'b1;
        tick();
        iv2 = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        or1 = 1'b1; or2 = 1'b1;
        iv1 = 1'b1; inv1 = 1'b0; d1 = $urandom;
        iv2 = 1'b1; inv2 = 1'b1; d2 = {$urandom, $urandom, $urandom, $urandom};
        tick();
        iv1 = 1'b0; iv2 = 1'b0;
        n_checks++;
        if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: got %b %b, required 1 1", busy1, busy2);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({ov1, od1, busy1} !== 34'b0 || {ov2, od2, busy2} !== 130'b0) begin
            n_fail++;
            $display("FAIL mid_clear: got a v=%b d=%h busy=%b b v=%b d=%h busy=%b, required all 0",
                     ov1, od1, busy1, ov2, od2, busy2);
        end
        q1.delete(); q2.delete();
        @(posedge clk);
        #3 reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (ov1 !== 1'b0 || ov2 !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_stale%0d: got %b %b, required 0 0", c, ov1, ov2);
            end
        end
        iv1 = 1'b1; inv1 = 1'b0; d1 = 32'h00000000;
        tick();
        iv1 = 1'b0;
        n_checks++;
        if (ov1 !== 1'b1 || od1 !== 32'h63636363) begin
            n_fail++;
            $display("FAIL mid_after: got v=%b d=%h, required 1 63636363", ov1, od1);
        end
        drain();
    endtask

    task automatic test_bubble();
        int pat [3] = '{1, 0, 1};
        int want;
        or2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            iv2 = (k < 3) ? 1'(pat[k]) : 1'b0;
            inv2 = 1'b0;
            d2 = {$urandom, $urandom, $urandom, $urandom};
            tick();
            want = (k >= 1 && k <= 3) ? pat[k-1] : 0;
            n_checks++;
            if (ov2 !== 1'(want)) begin
                n_fail++;
                $display("FAIL bubble_c%0d: out_valid %b, required %0d", k + 1, ov2, want);
            end
        end
        iv2 = 1'b0;
        drain();
    endtask

    initial begin
        build_model();
        test_reset();
        test_forward_latency();
        test_inverse_alternate();
        test_sweep();
        test_backpressure();
        test_reset_mid();
        test_bubble();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
